// File: rtl/mbm_log_mult_pipe_pkg.sv
// Shared sizing helpers for the log-domain multiplier: fraction width, clog2 and the
// default bias correction (2^-4 expressed in fraction LSBs).
package mbm_log_mult_pipe_pkg;

    localparam int DEF_WIDTH = 8;

    function automatic int frac_w(input int width);
        return width - 1;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // 2^-4 of the fraction scale; floor at one LSB for very narrow operands
    function automatic int def_corr(input int width);
        return (width > 5) ? (1 << (width - 5)) : 1;
    endfunction

endpackage

// File: rtl/mbm_log_mult_pipe_lod.sv
// Leading-one detector: position of the highest set bit plus an all-zero flag.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of the operand.
module mbm_log_mult_pipe_lod
    import mbm_log_mult_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0]        din,
    output logic [clog2(WIDTH)-1:0] k,
    output logic                    zero
);
    localparam int KW = clog2(WIDTH);

    always_comb begin
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (din[i]) k = KW'(i);
        end
    end

    assign zero = (din == '0);

endmodule

// File: rtl/mbm_log_mult_pipe.sv
// Pipelined Mitchell / minimally-biased log-domain multiplier (LOD, fraction add, antilog).
// Latency: 3 cycles from accepted operands to out_valid, one product per cycle.
// Backpressure: valid/ready stall chain; a stalled stage holds, in_ready drops when all 3 are full.
module mbm_log_mult_pipe
    import mbm_log_mult_pipe_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CORR_C = def_corr(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 corr_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 out_carry
);
    localparam int F  = frac_w(WIDTH);
    localparam int KW = clog2(WIDTH);
    localparam int EW = clog2(2 * WIDTH);
    localparam int PW = 2 * WIDTH;
    // wide enough for the (F+1)-bit mantissa shifted left by up to 2*WIDTH-1
    localparam int SW = 3 * WIDTH;

    localparam logic [KW-1:0]  F_K  = KW'(F);
    localparam logic [F+1:0]   FMAX = (F + 2)'((1 << F) - 1);

    typedef struct packed {
        logic [KW-1:0] k_a, k_b;
        logic [F-1:0]  x_a, x_b;
        logic          zero;
        logic          corr;
    } s1_t;

    typedef struct packed {
        logic [EW-1:0] e;
        logic [F-1:0]  frac;
        logic          carry;
        logic          zero;
    } s2_t;

    logic          v1, v2;
    logic          en1, en2, en3;
    s1_t           s1_d, s1_q;
    s2_t           s2_d, s2_q;
    logic [KW-1:0] k_a, k_b;
    logic          z_a, z_b;
    logic [F:0]    fsum;
    logic [F+1:0]  csum;
    logic [PW-1:0] p_d;

    assign en3      = ~out_valid | out_ready;
    assign en2      = ~v2 | en3;
    assign en1      = ~v1 | en2;
    assign in_ready = en1;

    mbm_log_mult_pipe_lod #(.WIDTH(WIDTH)) u_lod_a (.din(in_a), .k(k_a), .zero(z_a));
    mbm_log_mult_pipe_lod #(.WIDTH(WIDTH)) u_lod_b (.din(in_b), .k(k_b), .zero(z_b));

    always_comb begin
        s1_d.k_a  = k_a;
        s1_d.k_b  = k_b;
        s1_d.x_a  = F'(in_a << (F_K - k_a));
        s1_d.x_b  = F'(in_b << (F_K - k_b));
        s1_d.zero = z_a | z_b;
        s1_d.corr = corr_en;
    end

    assign fsum = {1'b0, s1_q.x_a} + {1'b0, s1_q.x_b};
    assign csum = {2'b00, fsum[F-1:0]} + (F + 2)'(CORR_C);

    always_comb begin
        s2_d.frac = fsum[F-1:0];
        if (s1_q.corr) s2_d.frac = (csum > FMAX) ? '1 : csum[F-1:0];
        s2_d.carry = fsum[F];
        s2_d.e     = EW'(s1_q.k_a) + EW'(s1_q.k_b) + EW'(fsum[F]);
        s2_d.zero  = s1_q.zero;
    end

    assign p_d = s2_q.zero ? '0 : PW'((SW'({1'b1, s2_q.frac}) << s2_q.e) >> F);

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_p     <= '0;
            out_carry <= 1'b0;
            s1_q      <= '0;
            s2_q      <= '0;
        end else begin
            if (en1) begin
                v1 <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
            if (en2) begin
                v2 <= v1;
                if (v1) s2_q <= s2_d;
            end
            if (en3) begin
                out_valid <= v2;
                if (v2) begin
                    out_p     <= p_d;
                    out_carry <= s2_q.carry & ~s2_q.zero;
                end
            end
        end
    end

endmodule
